blind_pixel_tpg: RTL and testbench



---
 rtl/blind_pixel_pkg.sv | 43 ++++
 rtl/blind_pixel_tpg_xy.sv | 43 ++++
 rtl/blind_pixel_tpg.sv | 186 ++++++++++++++++++
 tb/tb_blind_pixel_tpg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blind_pixel_pkg.sv
// Shared constants, state encoding and control-packet helper for the blind-pixel test-pattern generator.
package blind_pixel_pkg;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  localparam logic [1:0] PAT_FLAT  = 2'd0;
  localparam logic [1:0] PAT_HRAMP = 2'd1;
  localparam logic [1:0] PAT_VRAMP = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_SIZE = 2'd1;
  localparam logic [1:0] ADDR_FLAT = 2'd2;

  localparam logic [3:0] CTRL_LAST_BEAT = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL_HDR,
    ST_CTRL_BODY,
    ST_VID_HDR,
    ST_VID_PIX
  } state_t;

  // Control-packet body: width nibbles MSB first, then height, then interlace (always 0).
  function automatic logic [3:0] ctrl_nibble(input logic [3:0] beat,
                                             input logic [15:0] width,
                                             input logic [15:0] height);
    case (beat)
      4'd0:    ctrl_nibble = width[15:12];
      4'd1:    ctrl_nibble = width[11:8];
      4'd2:    ctrl_nibble = width[7:4];
      4'd3:    ctrl_nibble = width[3:0];
      4'd4:    ctrl_nibble = height[15:12];
      4'd5:    ctrl_nibble = height[11:8];
      4'd6:    ctrl_nibble = height[7:4];
      4'd7:    ctrl_nibble = height[3:0];
      default: ctrl_nibble = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/blind_pixel_tpg_xy.sv
// Raster x/y counter: x runs 0..W-1, then wraps and y increments. Exposes the following
// coordinate so the top can register the next pixel value in the same cycle it advances.
module blind_pixel_tpg_xy (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_advance,
  input  logic [15:0] i_width,
  input  logic [15:0] i_height,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic [15:0] o_x_nxt,
  output logic [15:0] o_y_nxt,
  output logic        o_last,
  output logic        o_last_nxt
);

  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        w_x_wrap;

  assign w_x_wrap   = (r_x == i_width - 16'd1);
  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_x_nxt    = w_x_wrap ? 16'd0 : r_x + 16'd1;
  assign o_y_nxt    = w_x_wrap ? r_y + 16'd1 : r_y;
  assign o_last     = w_x_wrap && (r_y == i_height - 16'd1);
  assign o_last_nxt = (o_x_nxt == i_width - 16'd1) && (o_y_nxt == i_height - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      r_x <= o_x_nxt;
      r_y <= o_y_nxt;
    end
  end

endmodule

// File: rtl/blind_pixel_tpg.sv
// Avalon-ST video test-pattern generator: control packet + single-plane video packet per frame.
//   state        | meaning
//   ST_IDLE      | no output, waiting for enable with non-zero geometry
//   ST_CTRL_HDR  | presenting control-packet type beat 0xF (sop)
//   ST_CTRL_BODY | presenting the 9 width/height/interlace nibbles
//   ST_VID_HDR   | presenting video-packet type beat 0x0 (sop)
//   ST_VID_PIX   | presenting pixels in raster order
module blind_pixel_tpg
  import blind_pixel_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DEF_WIDTH  = 640,
  parameter int DEF_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            av_address,
  input  logic                  av_write,
  input  logic [31:0]           av_writedata,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket
);

  logic                  r_enable;
  logic [1:0]            r_pattern;
  logic [15:0]           r_width;
  logic [15:0]           r_height;
  logic [DATA_WIDTH-1:0] r_flat;

  logic [1:0]            r_sh_pattern;
  logic [15:0]           r_sh_width;
  logic [15:0]           r_sh_height;
  logic [DATA_WIDTH-1:0] r_sh_flat;

  state_t                r_state;
  logic [3:0]            r_beat;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_sop;
  logic                  r_eop;

  logic        w_xfer;
  logic        w_go;
  logic        w_frame_boundary;
  logic        w_xy_clear;
  logic        w_xy_adv;
  logic [15:0] w_x;
  logic [15:0] w_y;
  logic [15:0] w_x_nxt;
  logic [15:0] w_y_nxt;
  logic        w_last;
  logic        w_last_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable  <= 1'b0;
      r_pattern <= PAT_FLAT;
      r_width   <= 16'(DEF_WIDTH);
      r_height  <= 16'(DEF_HEIGHT);
      r_flat    <= '0;
    end else if (av_write) begin
      case (av_address)
        ADDR_CTRL: begin
          r_enable  <= av_writedata[0];
          r_pattern <= av_writedata[2:1];
        end
        ADDR_SIZE: begin
          r_width  <= av_writedata[15:0];
          r_height <= av_writedata[31:16];
        end
        ADDR_FLAT: r_flat <= av_writedata[DATA_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  function automatic logic [DATA_WIDTH-1:0] pix(input logic [1:0] pat, input logic [15:0] x,
                                                input logic [15:0] y, input logic [DATA_WIDTH-1:0] flat);
    case (pat)
      PAT_FLAT:  pix = flat;
      PAT_HRAMP: pix = DATA_WIDTH'(x);
      PAT_VRAMP: pix = DATA_WIDTH'(y);
      default:   pix = (x[3] ^ y[3]) ? '1 : '0;
    endcase
  endfunction

  assign w_xfer           = r_valid & dout_ready;
  assign w_go             = r_enable && (r_width != 16'd0) && (r_height != 16'd0);
  assign w_frame_boundary = (r_state == ST_IDLE) || ((r_state == ST_VID_PIX) && w_xfer && w_last);
  assign w_xy_clear       = (r_state == ST_CTRL_BODY) && w_xfer && (r_beat == CTRL_LAST_BEAT);
  assign w_xy_adv         = (r_state == ST_VID_PIX) && w_xfer && !w_last;

  blind_pixel_tpg_xy u_xy (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_xy_clear),
    .i_advance  (w_xy_adv),
    .i_width    (r_sh_width),
    .i_height   (r_sh_height),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_x_nxt    (w_x_nxt),
    .o_y_nxt    (w_y_nxt),
    .o_last     (w_last),
    .o_last_nxt (w_last_nxt)
  );

  // Outputs describe the beat currently offered; they only move on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_sh_pattern <= PAT_FLAT;
      r_sh_width   <= 16'(DEF_WIDTH);
      r_sh_height  <= 16'(DEF_HEIGHT);
      r_sh_flat    <= '0;
    end else if (w_frame_boundary) begin
      if (w_go) begin
        r_state      <= ST_CTRL_HDR;
        r_data       <= DATA_WIDTH'(PKT_CTRL);
        r_valid      <= 1'b1;
        r_sop        <= 1'b1;
        r_eop        <= 1'b0;
        r_sh_pattern <= r_pattern;
        r_sh_width   <= r_width;
        r_sh_height  <= r_height;
        r_sh_flat    <= r_flat;
      end else begin
        r_state <= ST_IDLE;
        r_data  <= '0;
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
      end
    end else if (w_xfer) begin
      case (r_state)
        ST_CTRL_HDR: begin
          r_state <= ST_CTRL_BODY;
          r_beat  <= 4'd0;
          r_data  <= DATA_WIDTH'(ctrl_nibble(4'd0, r_sh_width, r_sh_height));
          r_sop   <= 1'b0;
          r_eop   <= 1'b0;
        end
        ST_CTRL_BODY: begin
          if (r_beat == CTRL_LAST_BEAT) begin
            r_state <= ST_VID_HDR;
            r_data  <= DATA_WIDTH'(PKT_VIDEO);
            r_sop   <= 1'b1;
            r_eop   <= 1'b0;
          end else begin
            r_beat <= r_beat + 4'd1;
            r_data <= DATA_WIDTH'(ctrl_nibble(r_beat + 4'd1, r_sh_width, r_sh_height));
            r_eop  <= ((r_beat + 4'd1) == CTRL_LAST_BEAT);
          end
        end
        ST_VID_HDR: begin
          r_state <= ST_VID_PIX;
          r_data  <= pix(r_sh_pattern, w_x, w_y, r_sh_flat);
          r_sop   <= 1'b0;
          r_eop   <= w_last;
        end
        ST_VID_PIX: begin
          r_data <= pix(r_sh_pattern, w_x_nxt, w_y_nxt, r_sh_flat);
          r_eop  <= w_last_nxt;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dout_data          = r_data;
  assign dout_valid         = r_valid;
  assign dout_startofpacket = r_sop;
  assign dout_endofpacket   = r_eop;

endmodule

// File: tb/tb_blind_pixel_tpg.sv
// Directed bench for blind_pixel_tpg: beats are logged as {sop, eop, data} and compared to hand-built vectors.
module tb_blind_pixel_tpg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  av_address = '0;
  logic        av_write = 1'b0;
  logic [31:0] av_writedata = '0;
  logic [9:0]  dout_data;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_startofpacket;
  logic        dout_endofpacket;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_stall = 0;
  bit          rnd_mode = 1'b0;
  bit          prev_stall = 1'b0;
  logic [11:0] prev_beat = '0;
  logic [11:0] q_beat[$];
  int          q_cyc[$];

  // 4x2 frame, horizontal ramp: {sop, eop, data}
  logic [11:0] exp_a[19] = '{12'h80F, 12'h000, 12'h000, 12'h000, 12'h004, 12'h000, 12'h000,
                             12'h000, 12'h002, 12'h400, 12'h800, 12'h000, 12'h001, 12'h002,
                             12'h003, 12'h000, 12'h001, 12'h002, 12'h403};

  blind_pixel_tpg dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .av_address         (av_address),
    .av_write           (av_write),
    .av_writedata       (av_writedata),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_ready         (dout_ready),
    .dout_startofpacket (dout_startofpacket),
    .dout_endofpacket   (dout_endofpacket)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    dout_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Beat logger and hold-while-stalled checker.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_beat", 32'({dout_startofpacket, dout_endofpacket, dout_data}), 32'(prev_beat));
        chk("hold_valid", 32'(dout_valid), 32'd1);
      end
      if (dout_valid && dout_ready) begin
        q_beat.push_back({dout_startofpacket, dout_endofpacket, dout_data});
        q_cyc.push_back(cyc);
      end
      prev_stall = dout_valid && !dout_ready;
      prev_beat  = {dout_startofpacket, dout_endofpacket, dout_data};
      if (prev_stall) n_stall++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    av_address   = a;
    av_writedata = d;
    av_write     = 1'b1;
    @(posedge clk);
    #1;
    av_write = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (q_beat.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk("wait_beats", 32'(q_beat.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (dout_valid && c < budget);
    chk("wait_idle", 32'(dout_valid), 32'd0);
  endtask

  task automatic chk_frame_a(input string tag);
    chk({tag, "_len"}, 32'(q_beat.size()), 32'd19);
    for (int i = 0; i < 19 && i < q_beat.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(q_beat[i]), 32'(exp_a[i]));
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_data", 32'(dout_data), 32'd0);
    chk("rst_sop", 32'(dout_startofpacket), 32'd0);
    chk("rst_eop", 32'(dout_endofpacket), 32'd0);
    #10 rst_n = 1'b1;

    // 4x2 ramp, ready held high: header timing, sequence, zero-gap, then disable mid-frame
    reg_wr(2'd1, 32'h0002_0004);
    reg_wr(2'd0, 32'h0000_0003);
    chk("en_edgeN_valid", 32'(dout_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("en_edgeN1_valid", 32'(dout_valid), 32'd1);
    chk("en_edgeN1_data", 32'(dout_data), 32'h00F);
    chk("en_edgeN1_sop", 32'(dout_startofpacket), 32'd1);
    wait_beats(20, 200);
    for (int i = 0; i < 19; i++)
      chk($sformatf("f1_beat%0d", i), 32'(q_beat[i]), 32'(exp_a[i]));
    chk("f2_hdr", 32'(q_beat[19]), 32'h80F);
    chk("f2_gap", 32'(q_cyc[19] - q_cyc[18]), 32'd1);
    reg_wr(2'd0, 32'h0000_0002);
    wait_idle(200);
    chk("stop_len", 32'(q_beat.size()), 32'd38);
    chk("stop_eop", 32'(q_beat[q_beat.size()-1]), 32'h403);
    repeat (5) @(posedge clk);
    #1;
    chk("stop_stays_idle", 32'(dout_valid), 32'd0);

    // Random backpressure: same one frame
    q_beat.delete();
    q_cyc.delete();
    rnd_mode = 1'b1;
    reg_wr(2'd0, 32'h0000_0003);
    reg_wr(2'd0, 32'h0000_0000);
    wait_beats(19, 500);
    wait_idle(500);
    rnd_mode = 1'b0;
    chk_frame_a("rnd");
    chk("rnd_stalls_seen", 32'(n_stall > 0), 32'd1);

    // Checkerboard 16x16
    q_beat.delete();
    q_cyc.delete();
    reg_wr(2'd1, 32'h0010_0010);
    reg_wr(2'd0, 32'h0000_0007);
    reg_wr(2'd0, 32'h0000_0000);
    wait_beats(267, 2000);
    wait_idle(200);
    chk("chk_len", 32'(q_beat.size()), 32'd267);
    if (q_beat.size() >= 267) begin
      chk("chk_w_nib0", 32'(q_beat[3]), 32'h001);
      chk("chk_px_0_0", 32'(q_beat[11]), 32'h000);
      chk("chk_px_8_0", 32'(q_beat[19]), 32'h3FF);
      chk("chk_px_0_8", 32'(q_beat[139]), 32'h3FF);
      chk("chk_px_8_8", 32'(q_beat[147]), 32'h000);
      chk("chk_px_last", 32'(q_beat[266]), 32'h400);
    end

    // Width write during pixels takes effect next frame
    q_beat.delete();
    q_cyc.delete();
    reg_wr(2'd1, 32'h0002_0004);
    reg_wr(2'd0, 32'h0000_0003);
    wait_beats(12, 200);
    reg_wr(2'd1, 32'h0002_0008);
    wait_beats(20, 200);
    reg_wr(2'd0, 32'h0000_0000);
    wait_idle(300);
    chk("wchg_len", 32'(q_beat.size()), 32'd46);
    if (q_beat.size() >= 46) begin
      chk("wchg_f1_last", 32'(q_beat[18]), 32'h403);
      chk("wchg_f2_hdr", 32'(q_beat[19]), 32'h80F);
      chk("wchg_f2_w_lo", 32'(q_beat[23]), 32'h008);
      chk("wchg_f2_h_lo", 32'(q_beat[27]), 32'h002);
      chk("wchg_px_7_0", 32'(q_beat[37]), 32'h007);
      chk("wchg_px_6_1", 32'(q_beat[44]), 32'h006);
      chk("wchg_px_7_1", 32'(q_beat[45]), 32'h407);
    end

    // Zero height keeps the block idle
    q_beat.delete();
    q_cyc.delete();
    reg_wr(2'd1, 32'h0000_0004);
    reg_wr(2'd0, 32'h0000_0003);
    repeat (10) @(posedge clk);
    #1;
    chk("h0_valid", 32'(dout_valid), 32'd0);
    chk("h0_beats", 32'(q_beat.size()), 32'd0);
    reg_wr(2'd0, 32'h0000_0000);

    // Reset during control body
    reg_wr(2'd1, 32'h0002_0004);
    reg_wr(2'd0, 32'h0000_0003);
    wait_beats(3, 100);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_data", 32'(dout_data), 32'd0);
    chk("arst_sop", 32'(dout_startofpacket), 32'd0);
    chk("arst_eop", 32'(dout_endofpacket), 32'd0);
    #12 rst_n = 1'b1;
    q_beat.delete();
    q_cyc.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("arst_stays_idle", 32'(dout_valid), 32'd0);
    reg_wr(2'd1, 32'h0002_0004);
    reg_wr(2'd0, 32'h0000_0003);
    reg_wr(2'd0, 32'h0000_0000);
    wait_beats(19, 200);
    wait_idle(200);
    chk_frame_a("arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
